fp8_skew_feeder: RTL

- Operand injector directly upstream of an N×N grid of FP8_PE cells.
- Accepts one k-step per beat: N FP8 A operands (one per row) and N FP8 B operands (one per column).
- Applies the systolic diagonal skew: lane i is delayed i cycles. Drives the per-anti-diagonal clear pulses, flushes the pipeline, and signals when every accumulator holds the final tile result.

---
 rtl/fp8_skew_feeder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fp8_skew_feeder.sv
// fp8_skew_feeder: operand injector for an N x N FP8 systolic grid.
// Accepts one k-step per beat (N A operands, N B operands), applies the
// diagonal skew (lane k delayed 1+k cycles), drives the per-anti-diagonal
// clear chain, flushes the grid and pulses tile_done when every PE holds
// its final accumulator.
// Optional feature macro: FEEDER_STALL_CNT_EN adds stall_cnt[15:0], a
// saturating count of STREAM cycles without an offered beat.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready/in_last  beat handshake, in_last ends the tile
//   in_a/in_b                  N E4M3 operands each, lane i = [8i+7:8i]
//   a_edge/b_edge              skewed operands to PE(i,0) / PE(0,j)
//   clear_diag                 bit d clears every PE with i+j=d
//   busy                       high in any state except IDLE
//   tile_done                  one-cycle pulse, all PE results final
module fp8_skew_feeder #(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [8*N-1:0]   in_a,
  input  logic [8*N-1:0]   in_b,
  output logic [8*N-1:0]   a_edge,
  output logic [8*N-1:0]   b_edge,
  output logic [2*N-2:0]   clear_diag,
  output logic             busy,
  output logic             tile_done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int unsigned LW = 8;
  localparam int unsigned DW = 2 * N - 1;
  localparam int unsigned CW = $clog2(2 * N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_flush_cnt;
  logic [DW-1:0]   r_clr;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_tile_done;
  logic            w_fire;
  logic            w_clr_tok;
  logic            w_ready_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic [8*N-1:0]  w_inj_a;
  logic [8*N-1:0]  w_inj_b;

  assign w_fire = in_valid & (r_state == S_STREAM);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_nxt = S_CLEAR;
      S_CLEAR:  w_state_nxt = S_STREAM;
      S_STREAM: if (w_fire && in_last) w_state_nxt = S_FLUSH;
      S_FLUSH:  if (r_flush_cnt == CW'(DW - 1)) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: injected values and next values of the status registers
  always_comb begin
    w_inj_a     = '0;
    w_inj_b     = '0;
    w_clr_tok   = 1'b0;
    w_ready_nxt = (w_state_nxt == S_STREAM);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    if (r_state == S_CLEAR) w_clr_tok = 1'b1;
    // Anything other than an accepted beat injects zero bubbles on both sides
    if (w_fire) begin
      w_inj_a = in_a;
      w_inj_b = in_b;
    end
  end

  // Status outputs registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_tile_done <= 1'b0;
    end else begin
      r_in_ready  <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_tile_done <= w_done_nxt;
    end
  end

  // Flush length counter: counts 0..DW-1 while in FLUSH
  always_ff @(posedge clk) begin
    if (!rst)                    r_flush_cnt <= '0;
    else if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + CW'(1);
    else                         r_flush_cnt <= '0;
  end

  // Clear token chain: bit d lags the injection by 1+d cycles
  always_ff @(posedge clk) begin
    if (!rst) r_clr <= '0;
    else      r_clr <= {r_clr[DW-2:0], w_clr_tok};
  end

  // Per-lane skew shift registers: lane k holds 1+k bytes, oldest at the top
  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam int unsigned SW = LW * (k + 1);
    logic [SW-1:0] r_a_sr;
    logic [SW-1:0] r_b_sr;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_a_sr <= '0;
        r_b_sr <= '0;
      end else begin
        r_a_sr <= (r_a_sr << LW) | SW'(w_inj_a[LW*k +: LW]);
        r_b_sr <= (r_b_sr << LW) | SW'(w_inj_b[LW*k +: LW]);
      end
    end

    assign a_edge[LW*k +: LW] = r_a_sr[LW*k +: LW];
    assign b_edge[LW*k +: LW] = r_b_sr[LW*k +: LW];
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of bubble cycles in the current tile
  always_ff @(posedge clk) begin
    if (!rst)                    r_stall_cnt <= '0;
    else if (r_state == S_CLEAR) r_stall_cnt <= '0;
    else if (r_state == S_STREAM && !in_valid && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign tile_done  = r_tile_done;
  assign clear_diag = r_clr;

endmodule
